hex_display_scanner: RTL and testbench



---
 rtl/hex_disp_pkg.sv | 36 +++
 rtl/hex7seg_lut.sv | 11 +
 rtl/hex_display_scanner.sv | 127 ++++++++++++
 tb/tb_hex_display_scanner.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/hex_disp_pkg.sv
// Shared definitions for hex 7-segment display drivers: scan FSM states,
// the segment-off pattern and the hex-to-segment table.
package hex_disp_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

  // Active-high {dp, g..a} pattern with every segment dark.
  localparam logic [7:0] SEG_OFF = 8'h00;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] s;
    case (nibble)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/hex7seg_lut.sv
// Combinational hex nibble to active-high gfedcba segment decoder.
module hex7seg_lut
  import hex_disp_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed 7-segment scanner: shadow-buffered hex value, per-digit dots,
// leading-zero suppression and a dark interval between digit slots.
module hex_display_scanner
  import hex_disp_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int CLK_DIV        = 50000,
  parameter int BLANK_CYCLES   = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dots,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     dig
);

  localparam int CNT_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int TW      = $clog2(CNT_MAX + 1);
  localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [TW-1:0]     SHOW_LAST  = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0]     BLANK_LAST = TW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [7:0]        SEG_MASK   = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] DIG_MASK   = (DIG_ACTIVE_LOW != 0) ? {DIGITS{1'b1}}
                                                                    : {DIGITS{1'b0}};

  scan_state_e          state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [4*DIGITS-1:0]  shd_data_q, shd_data_d;
  logic [DIGITS-1:0]    shd_dots_q, shd_dots_d;
  logic [7:0]           seg_q, seg_d;
  logic [DIGITS-1:0]    dig_q, dig_d;

  logic [3:0] cur_nib;
  logic [6:0] cur_seg7;
  logic       cur_dot;
  logic       upper_zero;
  logic       cur_sup;

  assign cur_nib = shd_data_q[4*idx_q +: 4];
  assign cur_dot = shd_dots_q[idx_q];

  hex7seg_lut u_lut (
    .nibble_i (cur_nib),
    .seg_o    (cur_seg7)
  );

  // A digit is a leading zero only if it and everything above it is zero and dot-free.
  always_comb begin
    upper_zero = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if (j >= int'(idx_q)) begin
        if ((shd_data_q[4*j +: 4] != 4'h0) || shd_dots_q[j]) begin
          upper_zero = 1'b0;
        end
      end
    end
    cur_sup = blank_lz && (idx_q != '0) && upper_zero;
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q + 1'b1;
    idx_d      = idx_q;
    shd_data_d = load ? data : shd_data_q;
    shd_dots_d = load ? dots : shd_dots_q;
    seg_d      = seg_q;
    dig_d      = dig_q;
    case (state_q)
      ST_BLANK: begin
        if (timer_q == BLANK_LAST) begin
          // The lit pattern is frozen here for the whole slot, so later loads never tear it.
          state_d = ST_SHOW;
          timer_d = '0;
          seg_d   = (cur_sup ? SEG_OFF : {cur_dot, cur_seg7}) ^ SEG_MASK;
          dig_d   = (DIGITS'(1) << idx_q) ^ DIG_MASK;
        end
      end
      ST_SHOW: begin
        if (timer_q == SHOW_LAST) begin
          state_d = ST_BLANK;
          timer_d = '0;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          seg_d   = SEG_OFF ^ SEG_MASK;
          dig_d   = DIG_MASK;
        end
      end
      default: begin
        state_d = ST_BLANK;
        timer_d = '0;
        seg_d   = SEG_OFF ^ SEG_MASK;
        dig_d   = DIG_MASK;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_BLANK;
      timer_q    <= '0;
      idx_q      <= '0;
      shd_data_q <= '0;
      shd_dots_q <= '0;
      seg_q      <= SEG_OFF ^ SEG_MASK;
      dig_q      <= DIG_MASK;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      idx_q      <= idx_d;
      shd_data_q <= shd_data_d;
      shd_dots_q <= shd_dots_d;
      seg_q      <= seg_d;
      dig_q      <= dig_d;
    end
  end

  assign seg = seg_q;
  assign dig = dig_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed scoreboard bench for hex_display_scanner (4 digits, 4-cycle slots, 1-cycle blank).
module tb_hex_display_scanner;

  localparam int DIGITS = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [4*DIGITS-1:0] data;
  logic [DIGITS-1:0]   dots;
  logic                load;
  logic                blank_lz;
  logic [7:0]          seg;
  logic [DIGITS-1:0]   dig;

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] dig;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  hex_display_scanner #(
    .DIGITS         (DIGITS),
    .CLK_DIV        (4),
    .BLANK_CYCLES   (1),
    .SEG_ACTIVE_LOW (1),
    .DIG_ACTIVE_LOW (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data     (data),
    .dots     (dots),
    .load     (load),
    .blank_lz (blank_lz),
    .seg      (seg),
    .dig      (dig)
  );

  function automatic logic [3:0] dig_on(input int k);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << k);
  endfunction

  // Push the expectation, advance one clock, then pop and compare away from the edge.
  task automatic step(input logic [7:0] es, input logic [3:0] ed, input string tag);
    exp_t e;
    e.seg = es;
    e.dig = ed;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    vectors++;
    assert ({seg, dig} === {e.seg, e.dig})
    else begin
      miscompares++;
      $error("FAIL %s: got seg=%h dig=%b, want seg=%h dig=%b", tag, seg, dig, e.seg, e.dig);
    end
  endtask

  task automatic slot(input int k, input logic [7:0] es, input string tag);
    for (int c = 0; c < 4; c++) step(es, dig_on(k), $sformatf("%s_idx%0d_c%0d", tag, k, c));
    step(8'hFF, 4'hF, $sformatf("%s_idx%0d_blank", tag, k));
  endtask

  task automatic slots012(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                          input string tag);
    slot(0, s0, tag);
    slot(1, s1, tag);
    slot(2, s2, tag);
  endtask

  initial begin
    rst      = 1'b1;
    data     = '0;
    dots     = '0;
    load     = 1'b0;
    blank_lz = 1'b0;
    step(8'hFF, 4'hF, "reset0");
    step(8'hFF, 4'hF, "reset1");
    rst = 1'b0;

    // Plain scan of zero; the load before idx3 must not alter idx3 itself.
    slots012(8'hC0, 8'hC0, 8'hC0, "scan");
    data = 16'h10A5;
    load = 1'b1;
    slot(3, 8'hC0, "scan");
    load = 1'b0;

    slots012(8'h92, 8'h88, 8'hC0, "enc");
    dots = 4'b0010;
    load = 1'b1;
    slot(3, 8'hF9, "enc");
    load = 1'b0;

    slots012(8'h92, 8'h08, 8'hC0, "dot");
    blank_lz = 1'b1;
    data     = 16'h00A5;
    dots     = 4'b0000;
    load     = 1'b1;
    slot(3, 8'hF9, "dot");
    load = 1'b0;

    slots012(8'h92, 8'h88, 8'hFF, "lz");
    data = 16'h0000;
    dots = 4'b0100;
    load = 1'b1;
    slot(3, 8'hFF, "lz");
    load = 1'b0;

    slots012(8'hC0, 8'hC0, 8'h40, "lzdot");
    blank_lz = 1'b0;
    data     = 16'h10A5;
    dots     = 4'b0000;
    load     = 1'b1;
    slot(3, 8'hC0, "lzdot");
    load = 1'b0;

    // Load arrives while idx0 is lit; it must only appear from idx1 on.
    step(8'h92, dig_on(0), "tear_c0");
    data = 16'hFFFF;
    load = 1'b1;
    step(8'h92, dig_on(0), "tear_c1");
    load = 1'b0;
    step(8'h92, dig_on(0), "tear_c2");
    step(8'h92, dig_on(0), "tear_c3");
    step(8'hFF, 4'hF, "tear_blank");
    slot(1, 8'h8E, "tear");
    slot(2, 8'h8E, "tear");
    slot(3, 8'h8E, "tear");

    // Reset beats a simultaneous load mid-slot.
    step(8'h8E, dig_on(0), "prio_c0");
    step(8'h8E, dig_on(0), "prio_c1");
    rst  = 1'b1;
    load = 1'b1;
    data = 16'h1234;
    dots = 4'b1111;
    step(8'hFF, 4'hF, "rst_prio");
    rst  = 1'b0;
    load = 1'b0;
    slot(0, 8'hC0, "post_rst");
    slot(1, 8'hC0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
